// File: rtl/decode_queue_pkg.sv
// Shared decode encodings: immediate formats, ALU operation codes, store widths
// and the decoded control bundle carried through the queue.
package decode_queue_pkg;

   localparam int imm_control_width   = 3;
   localparam int ALU_control_width   = 5;
   localparam int store_control_width = 2;

   typedef enum logic [imm_control_width-1:0] {
      i_type_imm, s_type_imm, b_type_imm, j_type_imm, u_type_imm
   } imm_e;

   typedef enum logic [ALU_control_width-1:0] {
      add_ALU, sub_ALU, xor_ALU, or_ALU, and_ALU, sll_ALU, srl_ALU, sra_ALU,
      slt_ALU, sltu_ALU, slli_ALU, srli_ALU, srai_ALU,
      lb_ALU, lh_ALU, lw_ALU, lbu_ALU, lhu_ALU,
      beq_ALU, bne_ALU, bge_ALU, bgeu_ALU,
      mul_ALU, mulh_ALU, mulhsu_ALU, mulhu_ALU, div_ALU, divu_ALU, rem_ALU, remu_ALU
   } alu_e;

   typedef enum logic [store_control_width-1:0] {sb, sh, sw} store_e;

   typedef struct packed {
      imm_e   imm;
      alu_e   alu;
      store_e store;
      logic   reg_write;
      logic   mem_read;
      logic   mem_write;
      logic   branch;
      logic   jump;
      logic   illegal;
   } ctrl_t;

   localparam int bundle_width = $bits(ctrl_t);

   localparam logic [6:0] op_reg    = 7'h33;
   localparam logic [6:0] op_imm    = 7'h13;
   localparam logic [6:0] op_load   = 7'h03;
   localparam logic [6:0] op_store  = 7'h23;
   localparam logic [6:0] op_branch = 7'h63;
   localparam logic [6:0] op_jal    = 7'h6f;
   localparam logic [6:0] op_jalr   = 7'h67;
   localparam logic [6:0] op_lui    = 7'h37;
   localparam logic [6:0] op_auipc  = 7'h17;

   localparam logic [6:0] f7_base   = 7'h00;
   localparam logic [6:0] f7_alt    = 7'h20;
   localparam logic [6:0] f7_muldiv = 7'h01;

   localparam ctrl_t ctrl_legal_base =
      '{i_type_imm, add_ALU, sw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t ctrl_illegal =
      '{i_type_imm, add_ALU, sw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   function automatic alu_e reg_alu(input logic [2:0] funct3);
      case (funct3)
         3'd0:    return add_ALU;
         3'd1:    return sll_ALU;
         3'd2:    return slt_ALU;
         3'd3:    return sltu_ALU;
         3'd4:    return xor_ALU;
         3'd5:    return srl_ALU;
         3'd6:    return or_ALU;
         default: return and_ALU;
      endcase
   endfunction

   function automatic alu_e muldiv_alu(input logic [2:0] funct3);
      case (funct3)
         3'd0:    return mul_ALU;
         3'd1:    return mulh_ALU;
         3'd2:    return mulhsu_ALU;
         3'd3:    return mulhu_ALU;
         3'd4:    return div_ALU;
         3'd5:    return divu_ALU;
         3'd6:    return rem_ALU;
         default: return remu_ALU;
      endcase
   endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake of the decode queue, plus flush.
interface decode_queue_if
   import decode_queue_pkg::*;
#(
   parameter int WORD_WIDTH = 32
);
   logic                           flush;
   logic                           in_valid;
   logic                           in_ready;
   logic [WORD_WIDTH-1:0]          in_instr;
   logic [WORD_WIDTH-1:0]          in_pc;
   logic                           out_valid;
   logic                           out_ready;
   logic [WORD_WIDTH-1:0]          out_pc;
   logic [WORD_WIDTH-1:0]          out_instr;
   logic [4:0]                     out_rd;
   logic [4:0]                     out_rs1;
   logic [4:0]                     out_rs2;
   logic [imm_control_width-1:0]   out_imm_control;
   logic [ALU_control_width-1:0]   out_ALU_control;
   logic [store_control_width-1:0] out_store_control;
   logic                           out_reg_write;
   logic                           out_mem_read;
   logic                           out_mem_write;
   logic                           out_branch;
   logic                           out_jump;
   logic                           out_illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_rd, out_rs1, out_rs2,
             out_imm_control, out_ALU_control, out_store_control, out_reg_write,
             out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_rd, out_rs1, out_rs2,
             out_imm_control, out_ALU_control, out_store_control, out_reg_write,
             out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
   );
endinterface

// File: rtl/decode_queue_rv_decode_logic.sv
// Combinational RV32I (optionally M) decoder: instruction fields in, control bundle out.
module rv_decode_logic
   import decode_queue_pkg::*;
#(
   parameter int ENABLE_M = 0
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [4:0] rd,
   output ctrl_t      ctrl
);

   ctrl_t c;
   logic  legal;
   logic  wr;

   always_comb begin
      c     = ctrl_legal_base;
      legal = 1'b1;
      wr    = 1'b0;
      case (opcode)
         op_reg: begin
            wr = 1'b1;
            case (funct7)
               f7_base:   c.alu = reg_alu(funct3);
               f7_alt: begin
                  if (funct3 == 3'd0)      c.alu = sub_ALU;
                  else if (funct3 == 3'd5) c.alu = sra_ALU;
                  else                     legal = 1'b0;
               end
               f7_muldiv: begin
                  if (ENABLE_M != 0) c.alu = muldiv_alu(funct3);
                  else               legal = 1'b0;
               end
               default:   legal = 1'b0;
            endcase
         end
         op_imm: begin
            wr = 1'b1;
            case (funct3)
               3'd1:    c.alu = slli_ALU;
               3'd5: begin
                  if (funct7 == f7_alt) c.alu = srai_ALU;
                  else                  c.alu = srli_ALU;
               end
               default: c.alu = reg_alu(funct3);
            endcase
            // shift-amount forms only accept the two defined funct7 patterns
            if ((funct3 == 3'd1 || funct3 == 3'd5) && funct7 != f7_base && funct7 != f7_alt)
               legal = 1'b0;
         end
         op_load: begin
            wr         = 1'b1;
            c.mem_read = 1'b1;
            case (funct3)
               3'd0:    c.alu = lb_ALU;
               3'd1:    c.alu = lh_ALU;
               3'd2:    c.alu = lw_ALU;
               3'd4:    c.alu = lbu_ALU;
               3'd5:    c.alu = lhu_ALU;
               default: legal = 1'b0;
            endcase
         end
         op_store: begin
            c.imm       = s_type_imm;
            c.mem_write = 1'b1;
            case (funct3)
               3'd0:    c.store = sb;
               3'd1:    c.store = sh;
               3'd2:    c.store = sw;
               default: legal = 1'b0;
            endcase
         end
         op_branch: begin
            c.imm    = b_type_imm;
            c.branch = 1'b1;
            case (funct3)
               3'd0:    c.alu = beq_ALU;
               3'd1:    c.alu = bne_ALU;
               3'd4:    c.alu = slt_ALU;
               3'd5:    c.alu = bge_ALU;
               3'd6:    c.alu = sltu_ALU;
               3'd7:    c.alu = bgeu_ALU;
               default: legal = 1'b0;
            endcase
         end
         op_jal: begin
            c.imm  = j_type_imm;
            c.jump = 1'b1;
            wr     = 1'b1;
         end
         op_jalr: begin
            c.jump = 1'b1;
            wr     = 1'b1;
            if (funct3 != 3'd0) legal = 1'b0;
         end
         op_lui: begin
            c.imm = u_type_imm;
            c.alu = lw_ALU;
            wr    = 1'b1;
         end
         op_auipc: begin
            c.imm = u_type_imm;
            wr    = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      ctrl           = c;
      ctrl.reg_write = wr && (rd != 5'd0);
      if (!legal) ctrl = ctrl_illegal;
   end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes on push and holds bundles in a DEPTH-entry FIFO
// so fetch and execute run decoupled; flush drops everything queued.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int ENABLE_M   = 0
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WORD_WIDTH-1:0] pc_q    [DEPTH];
   logic [WORD_WIDTH-1:0] instr_q [DEPTH];
   ctrl_t                 ctrl_q  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   ctrl_t                 dec;
   ctrl_t                 head_ctrl;
   logic [WORD_WIDTH-1:0] head_instr;
   logic                  push;
   logic                  pop;

   rv_decode_logic #(.ENABLE_M(ENABLE_M)) u_decode (
      .opcode (bus.in_instr[6:0]),
      .funct3 (bus.in_instr[14:12]),
      .funct7 (bus.in_instr[31:25]),
      .rd     (bus.in_instr[11:7]),
      .ctrl   (dec)
   );

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ready depends only on occupancy, never on out_ready
   assign bus.in_ready  = !rst && (count < CNT_W'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid && bus.in_ready && !bus.flush;
   assign pop           = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
            ctrl_q[i]  <= '0;
         end
      end else if (bus.flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]    <= bus.in_pc;
            instr_q[wr_ptr] <= bus.in_instr;
            ctrl_q[wr_ptr]  <= dec;
            wr_ptr          <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_ctrl             = ctrl_q[rd_ptr];
   assign head_instr            = instr_q[rd_ptr];
   assign bus.out_pc            = pc_q[rd_ptr];
   assign bus.out_instr         = head_instr;
   assign bus.out_rd            = head_instr[11:7];
   assign bus.out_rs1           = head_instr[19:15];
   assign bus.out_rs2           = head_instr[24:20];
   assign bus.out_imm_control   = head_ctrl.imm;
   assign bus.out_ALU_control   = head_ctrl.alu;
   assign bus.out_store_control = head_ctrl.store;
   assign bus.out_reg_write     = head_ctrl.reg_write;
   assign bus.out_mem_read      = head_ctrl.mem_read;
   assign bus.out_mem_write     = head_ctrl.mem_write;
   assign bus.out_branch        = head_ctrl.branch;
   assign bus.out_jump          = head_ctrl.jump;
   assign bus.out_illegal       = head_ctrl.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (M off / M on) share stimulus and are
// compared every cycle against a queue-plus-table reference model.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic        in_ready;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  imm;
      logic [4:0]  alu;
      logic [1:0]  st;
      logic        rw, mr, mw, br, jp, ill;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] mq [$];

   decode_queue_if #(.WORD_WIDTH(32)) b0 ();
   decode_queue_if #(.WORD_WIDTH(32)) b1 ();

   assign b1.flush     = b0.flush;
   assign b1.in_valid  = b0.in_valid;
   assign b1.in_instr  = b0.in_instr;
   assign b1.in_pc     = b0.in_pc;
   assign b1.out_ready = b0.out_ready;

   decode_queue #(.WORD_WIDTH(32), .DEPTH(DEPTH), .ENABLE_M(0)) dut_m0 (.clk(clk), .rst(rst), .bus(b0));
   decode_queue #(.WORD_WIDTH(32), .DEPTH(DEPTH), .ENABLE_M(1)) dut_m1 (.clk(clk), .rst(rst), .bus(b1));

   always #5 clk = ~clk;

   obs_t obs0, obs1;
   assign obs0 = {b0.in_ready, b0.out_valid, b0.out_pc, b0.out_instr, b0.out_rd, b0.out_rs1,
                  b0.out_rs2, b0.out_imm_control, b0.out_ALU_control, b0.out_store_control,
                  b0.out_reg_write, b0.out_mem_read, b0.out_mem_write, b0.out_branch,
                  b0.out_jump, b0.out_illegal};
   assign obs1 = {b1.in_ready, b1.out_valid, b1.out_pc, b1.out_instr, b1.out_rd, b1.out_rs1,
                  b1.out_rs2, b1.out_imm_control, b1.out_ALU_control, b1.out_store_control,
                  b1.out_reg_write, b1.out_mem_read, b1.out_mem_write, b1.out_branch,
                  b1.out_jump, b1.out_illegal};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode, table driven from the instruction-set rules.
   function automatic ctrl_t ref_decode(input logic [31:0] w, input bit m);
      alu_e   op_tbl  [8] = '{add_ALU, sll_ALU, slt_ALU, sltu_ALU, xor_ALU, srl_ALU, or_ALU, and_ALU};
      alu_e   imm_tbl [8] = '{add_ALU, slli_ALU, slt_ALU, sltu_ALU, xor_ALU, srli_ALU, or_ALU, and_ALU};
      alu_e   ld_tbl  [8] = '{lb_ALU, lh_ALU, lw_ALU, add_ALU, lbu_ALU, lhu_ALU, add_ALU, add_ALU};
      bit     ld_ok   [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
      alu_e   br_tbl  [8] = '{beq_ALU, bne_ALU, add_ALU, add_ALU, slt_ALU, bge_ALU, sltu_ALU, bgeu_ALU};
      bit     br_ok   [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
      alu_e   m_tbl   [8] = '{mul_ALU, mulh_ALU, mulhsu_ALU, mulhu_ALU, div_ALU, divu_ALU, rem_ALU, remu_ALU};
      store_e st_tbl  [3] = '{sb, sh, sw};
      ctrl_t  e;
      bit     ok;
      bit     wr;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      e = '0;
      e.store = sw;
      ok = 1;
      wr = 0;
      if (op == 7'h33) begin
         wr = 1;
         if (f7 == 7'h00) e.alu = op_tbl[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) e.alu = sub_ALU;
         else if (f7 == 7'h20 && f3 == 3'd5) e.alu = sra_ALU;
         else if (f7 == 7'h01 && m) e.alu = m_tbl[f3];
         else ok = 0;
      end else if (op == 7'h13) begin
         wr = 1;
         e.alu = imm_tbl[f3];
         if (f3 == 3'd5 && f7 == 7'h20) e.alu = srai_ALU;
         if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) ok = 0;
      end else if (op == 7'h03) begin
         wr = 1;
         e.mem_read = 1;
         e.alu = ld_tbl[f3];
         ok = ld_ok[f3];
      end else if (op == 7'h23) begin
         e.imm = s_type_imm;
         e.mem_write = 1;
         ok = (f3 < 3'd3);
         if (ok) e.store = st_tbl[f3[1:0]];
      end else if (op == 7'h63) begin
         e.imm = b_type_imm;
         e.branch = 1;
         e.alu = br_tbl[f3];
         ok = br_ok[f3];
      end else if (op == 7'h6f) begin
         e.imm = j_type_imm;
         e.jump = 1;
         wr = 1;
      end else if (op == 7'h67) begin
         e.jump = 1;
         wr = 1;
         ok = (f3 == 3'd0);
      end else if (op == 7'h37) begin
         e.imm = u_type_imm;
         e.alu = lw_ALU;
         wr = 1;
      end else if (op == 7'h17) begin
         e.imm = u_type_imm;
         wr = 1;
      end else begin
         ok = 0;
      end
      if (!ok) begin
         e = '0;
         e.store = sw;
         e.illegal = 1;
      end else begin
         e.reg_write = wr && (w[11:7] != 5'd0);
      end
      return e;
   endfunction

   task automatic check_all();
      obs_t        o;
      string       p;
      ctrl_t       e;
      logic [31:0] ins;
      for (int id = 0; id < 2; id++) begin
         o = (id == 0) ? obs0 : obs1;
         p = (id == 0) ? "m0" : "m1";
         check({p, "_in_ready"}, 32'(o.in_ready), 32'(!rst && mq.size() < DEPTH));
         check({p, "_out_valid"}, 32'(o.valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            ins = mq[0][31:0];
            e = ref_decode(ins, id == 1);
            check({p, "_pc"}, o.pc, mq[0][63:32]);
            check({p, "_instr"}, o.instr, ins);
            check({p, "_rd"}, 32'(o.rd), 32'(ins[11:7]));
            check({p, "_rs1"}, 32'(o.rs1), 32'(ins[19:15]));
            check({p, "_rs2"}, 32'(o.rs2), 32'(ins[24:20]));
            check({p, "_imm"}, 32'(o.imm), 32'(e.imm));
            check({p, "_alu"}, 32'(o.alu), 32'(e.alu));
            check({p, "_store"}, 32'(o.st), 32'(e.store));
            check({p, "_strobes"}, 32'({o.rw, o.mr, o.mw, o.br, o.jp}),
                  32'({e.reg_write, e.mem_read, e.mem_write, e.branch, e.jump}));
            check({p, "_illegal"}, 32'(o.ill), 32'(e.illegal));
         end
      end
   endtask

   task automatic check_zero();
      obs_t o;
      for (int id = 0; id < 2; id++) begin
         o = (id == 0) ? obs0 : obs1;
         check("zero_pc", o.pc, 32'd0);
         check("zero_instr", o.instr, 32'd0);
         check("zero_fields", 32'({o.rd, o.rs1, o.rs2, o.imm, o.alu, o.st,
                                   o.rw, o.mr, o.mw, o.br, o.jp, o.ill}), 32'd0);
      end
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit r);
      bit pu;
      bit po;
      b0.in_valid  = v;
      b0.in_instr  = ins;
      b0.in_pc     = pc;
      b0.out_ready = ordy;
      b0.flush     = fl;
      rst          = r;
      @(posedge clk);
      if (r || fl) begin
         mq.delete();
      end else begin
         pu = v && (mq.size() < DEPTH);
         po = (mq.size() != 0) && ordy;
         if (po) void'(mq.pop_front());
         if (pu) mq.push_back({pc, ins});
      end
      #1;
      check_all();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [9];
      logic [31:0] w;
      int          k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = ops[k];
      case ($urandom_range(0, 3))
         0:       w[31:25] = 7'h00;
         1:       w[31:25] = 7'h20;
         2:       w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      step(0, 32'h0, 32'h0, 0, 0, 1);
      step(0, 32'h0, 32'h0, 0, 0, 1);
      check_zero();
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("rst_release_ready", 32'(obs0.in_ready), 32'd1);
      check_zero();

      step(1, 32'h00208133, 32'h100, 1, 0, 0);
      check("tp_add_valid", 32'(obs0.valid), 32'd1);
      check("tp_add_alu", 32'(obs0.alu), 32'(add_ALU));
      check("tp_add_regs", 32'({obs0.rd, obs0.rs1, obs0.rs2}), 32'({5'd2, 5'd1, 5'd2}));
      check("tp_add_rw_ill", 32'({obs0.rw, obs0.ill}), 32'b10);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("tp_add_drained", 32'(obs0.valid), 32'd0);

      step(1, 32'h40208133, 32'h104, 1, 0, 0);
      check("tp_sub_alu", 32'(obs0.alu), 32'(sub_ALU));
      step(1, 32'h00208023, 32'h108, 1, 0, 0);
      check("tp_sb_imm", 32'(obs0.imm), 32'(s_type_imm));
      check("tp_sb_store", 32'(obs0.st), 32'(sb));
      check("tp_sb_mw_rw", 32'({obs0.mw, obs0.rw}), 32'b10);
      step(0, 32'h0, 32'h0, 1, 0, 0);

      step(1, 32'h02208133, 32'h10c, 1, 0, 0);
      check("tp_mul_m0_illegal", 32'(obs0.ill), 32'd1);
      check("tp_mul_m1_alu", 32'(obs1.alu), 32'(mul_ALU));
      check("tp_mul_m1_legal", 32'(obs1.ill), 32'd0);
      step(0, 32'h0, 32'h0, 1, 0, 0);

      step(1, 32'h00310093, 32'h200, 0, 0, 0);
      step(1, 32'h00412103, 32'h204, 0, 0, 0);
      check("tp_full_ready", 32'(obs0.in_ready), 32'd0);
      step(1, 32'h005201a3, 32'h208, 0, 0, 0);
      check("tp_full_hold", 32'(obs0.in_ready), 32'd0);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("tp_ready_after_pop", 32'(obs0.in_ready), 32'd1);
      check("tp_order", obs0.instr, 32'h00412103);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("tp_drain_empty", 32'(obs0.valid), 32'd0);

      step(1, 32'h00a00513, 32'h300, 0, 0, 0);
      step(1, 32'h00b00593, 32'h304, 0, 0, 0);
      step(1, 32'h00c00613, 32'h308, 0, 1, 0);
      check("tp_flush_empty", 32'(obs0.valid), 32'd0);
      check("tp_flush_ready", 32'(obs0.in_ready), 32'd1);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("tp_flush_no_push", 32'(obs0.valid), 32'd0);

      step(1, 32'h00000000, 32'h400, 1, 0, 0);
      check("tp_zero_illegal", 32'(obs0.ill), 32'd1);
      check("tp_zero_strobes", 32'({obs0.rw, obs0.mr, obs0.mw, obs0.br, obs0.jp}), 32'd0);
      step(1, 32'h00000013, 32'h404, 1, 0, 0);
      check("tp_nop_alu", 32'(obs0.alu), 32'(add_ALU));
      check("tp_nop_rw", 32'(obs0.rw), 32'd0);
      step(0, 32'h0, 32'h0, 1, 0, 0);

      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
